// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: each of AW/W/B/AR/R is a wire pass-through or a 2-entry skid buffer.
// Latency: 0 cycles in pass-through, 1 cycle in skid mode; full throughput either way.
// Backpressure: skid mode absorbs up to 2 beats, then in_ready drops (registered). Optional counters: AXIL_SLICE_STATS_EN.

module axil_skid #(
    parameter int W    = 8,
    parameter bit MODE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_vld,
    output logic         o_in_rdy,
    input  logic [W-1:0] i_in_dat,
    output logic         o_out_vld,
    input  logic         i_out_rdy,
    output logic [W-1:0] o_out_dat
);
    generate
        if (MODE == 1'b0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst_n;
            assign o_in_rdy     = i_out_rdy;
            assign o_out_vld    = i_in_vld;
            assign o_out_dat    = i_in_dat;
        end else begin : g_skid
            typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

            state_t         r_state;
            logic           r_in_rdy;
            logic           r_out_vld;
            logic [W-1:0]   r_main;
            logic [W-1:0]   r_skid;
            logic           w_in_hs;
            logic           w_out_hs;

            assign w_in_hs   = i_in_vld && r_in_rdy;
            assign w_out_hs  = r_out_vld && i_out_rdy;
            assign o_in_rdy  = r_in_rdy;
            assign o_out_vld = r_out_vld;
            assign o_out_dat = r_main;

            // ready sits low through reset and rises on the first edge after release
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= ST_EMPTY;
                    r_in_rdy  <= 1'b0;
                    r_out_vld <= 1'b0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            r_in_rdy <= 1'b1;
                            if (w_in_hs) begin
                                r_state   <= ST_ONE;
                                r_out_vld <= 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_hs && !w_out_hs) begin
                                r_state  <= ST_FULL;
                                r_in_rdy <= 1'b0;
                            end else if (!w_in_hs && w_out_hs) begin
                                r_state   <= ST_EMPTY;
                                r_out_vld <= 1'b0;
                            end
                        end
                        ST_FULL: begin
                            if (w_out_hs) begin
                                r_state  <= ST_ONE;
                                r_in_rdy <= 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= ST_EMPTY;
                            r_in_rdy  <= 1'b0;
                            r_out_vld <= 1'b0;
                        end
                    endcase
                end
            end

            // payload flops carry no reset; validity is tracked by r_state alone
            always_ff @(posedge clk) begin
                if (w_in_hs && ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_out_hs))) begin
                    r_main <= i_in_dat;
                end else if ((r_state == ST_FULL) && w_out_hs) begin
                    r_main <= r_skid;
                end
                if (w_in_hs && (r_state == ST_ONE) && !w_out_hs) begin
                    r_skid <= i_in_dat;
                end
            end
        end
    endgenerate
endmodule

module axil_reg_slice #(
    parameter int  IS_64_BIT      = 0,
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter bit  AW_MODE        = 1'b1,
    parameter bit  W_MODE         = 1'b1,
    parameter bit  B_MODE         = 1'b1,
    parameter bit  AR_MODE        = 1'b1,
    parameter bit  R_MODE         = 1'b1,
    localparam int DW             = (IS_64_BIT != 0) ? 64 : 32,
    localparam int SW             = DW / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DW-1:0]             s_wdata,
    input  logic [SW-1:0]             s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DW-1:0]             s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DW-1:0]             m_wdata,
    output logic [SW-1:0]             m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DW-1:0]             m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
`ifdef AXIL_SLICE_STATS_EN
    ,
    output logic [31:0]               wr_count,
    output logic [31:0]               rd_count,
    output logic [15:0]               err_count
`endif
);
    axil_skid #(.W(AXI_ADDR_WIDTH), .MODE(AW_MODE)) u_aw (
        .clk(aclk), .rst_n(aresetn),
        .i_in_vld(s_awvalid), .o_in_rdy(s_awready), .i_in_dat(s_awaddr),
        .o_out_vld(m_awvalid), .i_out_rdy(m_awready), .o_out_dat(m_awaddr)
    );

    axil_skid #(.W(DW + SW), .MODE(W_MODE)) u_w (
        .clk(aclk), .rst_n(aresetn),
        .i_in_vld(s_wvalid), .o_in_rdy(s_wready), .i_in_dat({s_wdata, s_wstrb}),
        .o_out_vld(m_wvalid), .i_out_rdy(m_wready), .o_out_dat({m_wdata, m_wstrb})
    );

    axil_skid #(.W(2), .MODE(B_MODE)) u_b (
        .clk(aclk), .rst_n(aresetn),
        .i_in_vld(m_bvalid), .o_in_rdy(m_bready), .i_in_dat(m_bresp),
        .o_out_vld(s_bvalid), .i_out_rdy(s_bready), .o_out_dat(s_bresp)
    );

    axil_skid #(.W(AXI_ADDR_WIDTH), .MODE(AR_MODE)) u_ar (
        .clk(aclk), .rst_n(aresetn),
        .i_in_vld(s_arvalid), .o_in_rdy(s_arready), .i_in_dat(s_araddr),
        .o_out_vld(m_arvalid), .i_out_rdy(m_arready), .o_out_dat(m_araddr)
    );

    axil_skid #(.W(DW + 2), .MODE(R_MODE)) u_r (
        .clk(aclk), .rst_n(aresetn),
        .i_in_vld(m_rvalid), .o_in_rdy(m_rready), .i_in_dat({m_rdata, m_rresp}),
        .o_out_vld(s_rvalid), .i_out_rdy(s_rready), .o_out_dat({s_rdata, s_rresp})
    );

`ifdef AXIL_SLICE_STATS_EN
    logic       w_b_hs;
    logic       w_r_hs;
    logic [1:0] w_err_inc;

    assign w_b_hs    = s_bvalid && s_bready;
    assign w_r_hs    = s_rvalid && s_rready;
    // a B error and an R error in the same cycle add two
    assign w_err_inc = {1'b0, w_b_hs & s_bresp[1]} + {1'b0, w_r_hs & s_rresp[1]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else begin
            wr_count  <= wr_count + {31'd0, w_b_hs};
            rd_count  <= rd_count + {31'd0, w_r_hs};
            err_count <= err_count + {14'd0, w_err_inc};
        end
    end
`endif
endmodule

// File: tb/tb_axil_reg_slice.sv
// Directed bench for axil_reg_slice: skid instance (32-bit, all channels buffered) and pass-through instance (64-bit).
// Counter checks run only when AXIL_SLICE_STATS_EN is defined.
module tb_axil_reg_slice;
    logic aclk = 1'b0;
    logic aresetn;
    int   checks = 0;
    int   errors = 0;

    always #5 aclk = ~aclk;

    logic [31:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;

    logic [31:0] p_s_awaddr, p_m_awaddr, p_s_araddr, p_m_araddr;
    logic [63:0] p_s_wdata, p_m_wdata, p_s_rdata, p_m_rdata;
    logic [7:0]  p_s_wstrb, p_m_wstrb;
    logic [1:0]  p_s_bresp, p_m_bresp, p_s_rresp, p_m_rresp;
    logic p_s_awvalid, p_s_awready, p_s_wvalid, p_s_wready, p_s_bvalid, p_s_bready;
    logic p_s_arvalid, p_s_arready, p_s_rvalid, p_s_rready;
    logic p_m_awvalid, p_m_awready, p_m_wvalid, p_m_wready, p_m_bvalid, p_m_bready;
    logic p_m_arvalid, p_m_arready, p_m_rvalid, p_m_rready;

`ifdef AXIL_SLICE_STATS_EN
    logic [31:0] wr_count, rd_count, p_wr_count, p_rd_count;
    logic [15:0] err_count, p_err_count;
`endif

    axil_reg_slice dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef AXIL_SLICE_STATS_EN
        , .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
`endif
    );

    axil_reg_slice #(
        .IS_64_BIT(1), .AW_MODE(1'b0), .W_MODE(1'b0), .B_MODE(1'b0), .AR_MODE(1'b0), .R_MODE(1'b0)
    ) dut_pt (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(p_s_awaddr), .s_awvalid(p_s_awvalid), .s_awready(p_s_awready),
        .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb), .s_wvalid(p_s_wvalid), .s_wready(p_s_wready),
        .s_bresp(p_s_bresp), .s_bvalid(p_s_bvalid), .s_bready(p_s_bready),
        .s_araddr(p_s_araddr), .s_arvalid(p_s_arvalid), .s_arready(p_s_arready),
        .s_rdata(p_s_rdata), .s_rresp(p_s_rresp), .s_rvalid(p_s_rvalid), .s_rready(p_s_rready),
        .m_awaddr(p_m_awaddr), .m_awvalid(p_m_awvalid), .m_awready(p_m_awready),
        .m_wdata(p_m_wdata), .m_wstrb(p_m_wstrb), .m_wvalid(p_m_wvalid), .m_wready(p_m_wready),
        .m_bresp(p_m_bresp), .m_bvalid(p_m_bvalid), .m_bready(p_m_bready),
        .m_araddr(p_m_araddr), .m_arvalid(p_m_arvalid), .m_arready(p_m_arready),
        .m_rdata(p_m_rdata), .m_rresp(p_m_rresp), .m_rvalid(p_m_rvalid), .m_rready(p_m_rready)
`ifdef AXIL_SLICE_STATS_EN
        , .wr_count(p_wr_count), .rd_count(p_rd_count), .err_count(p_err_count)
`endif
    );

    task automatic init_inputs();
        aresetn = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
        p_s_awaddr = '0; p_s_awvalid = 1'b0; p_s_wdata = '0; p_s_wstrb = '0; p_s_wvalid = 1'b0;
        p_s_bready = 1'b0; p_s_araddr = '0; p_s_arvalid = 1'b0; p_s_rready = 1'b0;
        p_m_awready = 1'b0; p_m_wready = 1'b0; p_m_bresp = '0; p_m_bvalid = 1'b0;
        p_m_arready = 1'b0; p_m_rdata = '0; p_m_rresp = '0; p_m_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b00000) begin
            errors++; $display("FAIL rst_readies got %b exp 00000", {s_awready, s_wready, m_bready, s_arready, m_rready});
        end
        checks++;
        if ({m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid} !== 5'b00000) begin
            errors++; $display("FAIL rst_valids got %b exp 00000", {m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid});
        end
`ifdef AXIL_SLICE_STATS_EN
        checks++;
        if ({wr_count, rd_count, err_count} !== 80'd0) begin
            errors++; $display("FAIL rst_counts got %0d %0d %0d exp 0 0 0", wr_count, rd_count, err_count);
        end
`endif
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        checks++;
        if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b00000) begin
            errors++; $display("FAIL rst_release_rdy got %b exp 00000", {s_awready, s_wready, m_bready, s_arready, m_rready});
        end
        @(posedge aclk); #1;
        checks++;
        if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b11111) begin
            errors++; $display("FAIL rst_first_edge_rdy got %b exp 11111", {s_awready, s_wready, m_bready, s_arready, m_rready});
        end
    endtask

`ifdef AXIL_SLICE_STATS_EN
    task automatic test_stats();
        logic [1:0] bresps [3];
        logic [1:0] rresps [2];
        bresps = '{2'd0, 2'd2, 2'd0};
        rresps = '{2'd3, 2'd0};
        s_bready = 1'b1; s_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge aclk); #1;
            m_bvalid = (k < 3);
            m_bresp  = (k < 3) ? bresps[k] : 2'd0;
            m_rvalid = (k >= 1) && (k <= 2);
            m_rresp  = ((k >= 1) && (k <= 2)) ? rresps[k-1] : 2'd0;
            m_rdata  = 32'h5000 + k;
        end
        repeat (4) @(posedge aclk);
        #1;
        checks++;
        if (wr_count !== 32'd3) begin errors++; $display("FAIL stats_wr got %0d exp 3", wr_count); end
        checks++;
        if (rd_count !== 32'd2) begin errors++; $display("FAIL stats_rd got %0d exp 2", rd_count); end
        checks++;
        if (err_count !== 16'd2) begin errors++; $display("FAIL stats_err got %0d exp 2", err_count); end
        s_bready = 1'b0; s_rready = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        m_awready = 1'b1; m_arready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(posedge aclk); #1;
            if (i > 0) begin
                checks++;
                if (m_awvalid !== 1'b1 || m_awaddr !== 32'(4 * (i - 1))) begin
                    errors++; $display("FAIL b2b_aw[%0d] got v%b %h exp v1 %h", i - 1, m_awvalid, m_awaddr, 32'(4 * (i - 1)));
                end
                checks++;
                if (m_arvalid !== 1'b1 || m_araddr !== 32'h1000 + 32'(4 * (i - 1))) begin
                    errors++; $display("FAIL b2b_ar[%0d] got v%b %h exp v1 %h", i - 1, m_arvalid, m_araddr, 32'h1000 + 32'(4 * (i - 1)));
                end
                checks++;
                if (s_awready !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b exp 1", i - 1, s_awready); end
            end
            s_awvalid = (i < 8); s_arvalid = (i < 8);
            s_awaddr  = 32'(4 * i); s_araddr = 32'h1000 + 32'(4 * i);
        end
        @(posedge aclk); #1;
        checks++;
        if (m_awvalid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", m_awvalid); end
        m_awready = 1'b0; m_arready = 1'b0;
    endtask

    task automatic test_w_backpressure();
        int   sidx;
        int   rcv;
        logic acc;
        m_wready = 1'b1;
        @(posedge aclk); #1; s_wvalid = 1'b1; s_wdata = 32'hA0; s_wstrb = 4'h1;
        @(posedge aclk); #1; m_wready = 1'b0; s_wdata = 32'hA1; s_wstrb = 4'h2;
        @(posedge aclk); #1; s_wdata = 32'hA2; s_wstrb = 4'h3;
        checks++;
        if (s_wready !== 1'b0) begin errors++; $display("FAIL w_full_rdy got %b exp 0", s_wready); end
        repeat (3) begin
            @(posedge aclk); #1;
            checks++;
            if (s_wready !== 1'b0 || m_wvalid !== 1'b1 || m_wdata !== 32'hA0) begin
                errors++; $display("FAIL w_stall got rdy%b v%b %h exp rdy0 v1 a0", s_wready, m_wvalid, m_wdata);
            end
        end
        m_wready = 1'b1; sidx = 2; rcv = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            if (m_wvalid && m_wready) begin
                checks++;
                if (m_wdata !== 32'hA0 + 32'(rcv) || m_wstrb !== 4'(rcv + 1)) begin
                    errors++; $display("FAIL w_order[%0d] got %h/%h exp %h/%h", rcv, m_wdata, m_wstrb, 32'hA0 + 32'(rcv), 4'(rcv + 1));
                end
                rcv++;
            end
            acc = s_wvalid && s_wready;
            @(posedge aclk); #1;
            if (acc) sidx++;
            if (sidx < 5) begin
                s_wdata = 32'hA0 + 32'(sidx); s_wstrb = 4'(sidx + 1);
            end else begin
                s_wvalid = 1'b0;
            end
        end
        checks++;
        if (rcv !== 5) begin errors++; $display("FAIL w_count got %0d exp 5", rcv); end
        m_wready = 1'b0;
    endtask

    task automatic test_r_one_in_out();
        @(posedge aclk); #1; m_rvalid = 1'b1; m_rdata = 32'h11; m_rresp = 2'd0;
        @(posedge aclk); #1;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h11) begin errors++; $display("FAIL r_first got v%b %h exp v1 11", s_rvalid, s_rdata); end
        m_rdata = 32'h22; m_rresp = 2'd2; s_rready = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 32'h22 || s_rresp !== 2'd2) begin
            errors++; $display("FAIL r_swap got v%b %h/%0d exp v1 22/2", s_rvalid, s_rdata, s_rresp);
        end
        checks++;
        if (m_rready !== 1'b1) begin errors++; $display("FAIL r_one_rdy got %b exp 1", m_rready); end
        m_rvalid = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (s_rvalid !== 1'b0) begin errors++; $display("FAIL r_nodup got %b exp 0", s_rvalid); end
        s_rready = 1'b0;
    endtask

    task automatic test_b_channel();
        @(posedge aclk); #1; m_bvalid = 1'b1; m_bresp = 2'd1;
        @(posedge aclk); #1; m_bresp = 2'd2;
        @(posedge aclk); #1;
        checks++;
        if (m_bready !== 1'b0 || s_bvalid !== 1'b1 || s_bresp !== 2'd1) begin
            errors++; $display("FAIL b_full got rdy%b v%b %0d exp rdy0 v1 1", m_bready, s_bvalid, s_bresp);
        end
        m_bvalid = 1'b0; s_bready = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if (s_bresp !== 2'd2 || m_bready !== 1'b1) begin errors++; $display("FAIL b_skid got %0d rdy%b exp 2 rdy1", s_bresp, m_bready); end
        @(posedge aclk); #1;
        checks++;
        if (s_bvalid !== 1'b0) begin errors++; $display("FAIL b_empty got %b exp 0", s_bvalid); end
        s_bready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_awready = 1'b0; s_rready = 1'b0;
        @(posedge aclk); #1; s_awvalid = 1'b1; s_awaddr = 32'h100; m_rvalid = 1'b1; m_rdata = 32'h55;
        @(posedge aclk); #1; s_awaddr = 32'h104; m_rdata = 32'h66;
        @(posedge aclk); #1; s_awvalid = 1'b0; m_rvalid = 1'b0;
        checks++;
        if (m_awvalid !== 1'b1 || s_awready !== 1'b0 || m_rready !== 1'b0) begin
            errors++; $display("FAIL mid_full got v%b rdy%b rrdy%b exp v1 rdy0 rrdy0", m_awvalid, s_awready, m_rready);
        end
        #2; aresetn = 1'b0; #1;
        checks++;
        if ({m_awvalid, s_awready, s_rvalid, m_rready} !== 4'b0000) begin
            errors++; $display("FAIL mid_async got %b exp 0000", {m_awvalid, s_awready, s_rvalid, m_rready});
        end
        @(posedge aclk); #1;
        checks++;
        if ({s_awready, s_wready, m_bready, s_arready, m_rready} !== 5'b00000) begin
            errors++; $display("FAIL mid_in_rst got %b exp 00000", {s_awready, s_wready, m_bready, s_arready, m_rready});
        end
        #3; aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if ({s_awready, m_rready} !== 2'b11) begin errors++; $display("FAIL mid_release got %b exp 11", {s_awready, m_rready}); end
        m_awready = 1'b1; s_rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            checks++;
            if (m_awvalid !== 1'b0 || s_rvalid !== 1'b0) begin
                errors++; $display("FAIL mid_stale[%0d] got %b%b exp 00", i, m_awvalid, s_rvalid);
            end
        end
        s_awvalid = 1'b1; s_awaddr = 32'h200;
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        checks++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h200) begin
            errors++; $display("FAIL mid_fresh got v%b %h exp v1 200", m_awvalid, m_awaddr);
        end
        @(posedge aclk); #1;
        m_awready = 1'b0; s_rready = 1'b0;
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 2; i++) begin
            p_s_awaddr = 32'hDEAD_0000 ^ 32'(i); p_s_awvalid = (i == 0); p_m_awready = (i != 0);
            p_s_wdata = 64'h0123_4567_89AB_CDEF ^ {32'(i), 32'(i)}; p_s_wstrb = 8'hFF; p_s_wvalid = (i != 0); p_m_wready = (i == 0);
            p_m_bresp = 2'(i + 1); p_m_bvalid = (i == 0); p_s_bready = (i != 0);
            p_s_araddr = 32'hBEEF_0000 + 32'(i); p_s_arvalid = (i != 0); p_m_arready = (i == 0);
            p_m_rdata = 64'hFEDC_BA98_7654_3210 + 64'(i); p_m_rresp = 2'(3 - i); p_m_rvalid = (i == 0); p_s_rready = (i != 0);
            #1;
            checks++;
            if ({p_m_awaddr, p_m_awvalid, p_s_awready} !== {32'hDEAD_0000 ^ 32'(i), i == 0, i != 0}) begin
                errors++; $display("FAIL pt_aw[%0d] got %h %b%b", i, p_m_awaddr, p_m_awvalid, p_s_awready);
            end
            checks++;
            if ({p_m_wdata, p_m_wstrb, p_m_wvalid, p_s_wready} !== {64'h0123_4567_89AB_CDEF ^ {32'(i), 32'(i)}, 8'hFF, i != 0, i == 0}) begin
                errors++; $display("FAIL pt_w[%0d] got %h %h %b%b", i, p_m_wdata, p_m_wstrb, p_m_wvalid, p_s_wready);
            end
            checks++;
            if ({p_s_bresp, p_s_bvalid, p_m_bready} !== {2'(i + 1), i == 0, i != 0}) begin
                errors++; $display("FAIL pt_b[%0d] got %0d %b%b", i, p_s_bresp, p_s_bvalid, p_m_bready);
            end
            checks++;
            if ({p_m_araddr, p_m_arvalid, p_s_arready} !== {32'hBEEF_0000 + 32'(i), i != 0, i == 0}) begin
                errors++; $display("FAIL pt_ar[%0d] got %h %b%b", i, p_m_araddr, p_m_arvalid, p_s_arready);
            end
            checks++;
            if ({p_s_rdata, p_s_rresp, p_s_rvalid, p_m_rready} !== {64'hFEDC_BA98_7654_3210 + 64'(i), 2'(3 - i), i == 0, i != 0}) begin
                errors++; $display("FAIL pt_r[%0d] got %h %0d %b%b", i, p_s_rdata, p_s_rresp, p_s_rvalid, p_m_rready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        init_inputs();
        test_reset();
`ifdef AXIL_SLICE_STATS_EN
        test_stats();
`endif
        test_back_to_back();
        test_w_backpressure();
        test_r_one_in_out();
        test_b_channel();
        test_reset_mid();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
